riscv_word_packer: RTL and testbench
====================================

Name: riscv_word_packer

Overview:
- Collects `XLEN`-bit words one at a time over a valid/ready handshake into a concatenated N_SLOT × `XLEN` bus.
- It is the write-side counterpart of the N-input concatenated-bus selector. It uses the same slot packing, so slot i sits at bits [`XLEN*(i+1)-1 -: `XLEN].
- It sits between a word-serial producer (e.g. a load/CSR sequencer) and any consumer of a wide concatenated operand bus.
- It presents the packed bus with its own valid/ready handshake.

Parameters:
- N_SLOT, default 2: number of `XLEN`-bit slots in the packed bus. Must be >= 1.
- `XLEN (global macro from riscv_configs.v): word width. Not a module parameter.

Ports:
- i_clk, input, 1: clock. All state updates on the rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_flush, input, 1: synchronous abort. Discards the partial or held pack.
- i_word_valid, input, 1: producer word valid.
- o_word_ready, output, 1: packer can accept a word this cycle.
- i_word_data, input, `XLEN: word written into the current slot.
- i_word_last, input, 1: qualified by the word handshake. Closes the pack early; remaining slots read 0.
- o_pack_valid, output, 1: packed bus valid.
- i_pack_ready, input, 1: consumer accepts the pack.
- o_pack_data, output, N_SLOT*`XLEN: packed bus.
- o_pack_cnt, output, $clog2(N_SLOT+1): number of slots written in the presented pack (1..N_SLOT).

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: state=FILL, slot index=0, o_pack_data=0, o_pack_cnt=0, o_pack_valid=0, o_word_ready=1 (combinational from state; see below).
- States: FILL and HOLD.
- FILL:
  - o_word_ready = ~i_flush, o_pack_valid = 0.
  - A word is accepted when i_word_valid & o_word_ready. The word is written to slot[idx], and o_pack_cnt becomes idx+1.
  - If idx == N_SLOT-1 or i_word_last: go to HOLD and reset idx to 0. Otherwise idx increments by 1.
- HOLD:
  - o_pack_valid = 1, o_word_ready = 0.
  - o_pack_data and o_pack_cnt are stable until the handshake completes.
  - On i_pack_valid & i_pack_ready: go to FILL, clear o_pack_data to 0, clear o_pack_cnt to 0.
- Latency: o_pack_valid rises the cycle after the closing word is accepted.
- Throughput: at most one pack per (words + 1) cycles. There is no overlap between HOLD and the next FILL.
- Zero-fill: unwritten slots are always 0, because data is cleared on pack hand-off and on flush/reset.
- i_flush:
  - In any state, the next state is FILL with idx=0, data=0, cnt=0.
  - Flush has priority over a simultaneous word accept or pack accept. Neither completes; o_word_ready is low during flush.
- Reset mid-pack: identical to flush. Reset has priority over flush.
- idx never exceeds N_SLOT-1. No wrap is visible at the outputs.
- N_SLOT=1: every accepted word moves directly to HOLD with cnt=1.
- Producer rules: i_word_data and i_word_last are ignored when not accepted. i_word_last on a word landing in slot N_SLOT-1 is redundant and harmless.
- Consumer rules: i_pack_ready is ignored in FILL. Combinational i_pack_ready → o_word_ready paths are not allowed (ready depends on state and i_flush only).

Decomposition:
- Shared defines in riscv_configs.v: state encodings `PACK_FILL and `PACK_HOLD (1-bit).
- Slot write enable: one sub-module is natural, riscv_decoder. It is a parameterised $clog2(N_SLOT)-to-N_SLOT one-hot decoder with an enable, and produces per-slot write enables from idx and the accept strobe.
- The slot registers, counter and FSM stay in riscv_word_packer.

Test Plan (N_SLOT=4, XLEN=32):
- Full pack:
  - Stimulus: after reset, send 0x11111111, 0x22222222, 0x33333333, 0x44444444 on back-to-back cycles, i_pack_ready=1.
  - Response: o_pack_valid for 1 cycle, one cycle after the 4th accept; o_pack_data=0x44444444_33333333_22222222_11111111, cnt=4; o_word_ready back to 1 the following cycle.
- Early last:
  - Stimulus: send 0xA, then 0xB with i_word_last=1.
  - Response: o_pack_data=0x0_0_0000000B_0000000A (upper two slots 0), cnt=2.
- Consumer backpressure:
  - Stimulus: full pack with i_pack_ready=0 for 5 cycles, then 1.
  - Response: o_pack_data and cnt stable, o_word_ready=0 throughout HOLD; i_word_valid held high accepts nothing until the cycle after the pack handshake.
- Producer gaps:
  - Stimulus: 4 words with i_word_valid deasserted 2 cycles between each.
  - Response: same packed value as the full-pack case, and the slot order is preserved.
- Flush:
  - Stimulus: flush after 2 words.
  - Response: next cycle cnt=0 and data=0; a following 4-word pack contains only the new words.
  - Stimulus: flush asserted in HOLD together with i_pack_ready=1.
  - Response: the pack is discarded, with no extra valid cycle.
- Reset mid-pack:
  - Stimulus: i_rst after 3 words.
  - Response: all outputs return to reset values on the next edge, and o_word_ready=1.

Source files
------------

// File: rtl/riscv_word_packer_pkg.sv
// Shared word width, pack state encodings and state type for the word packer.
`ifndef RISCV_CONFIGS
`define RISCV_CONFIGS
`define XLEN 32
`define PACK_FILL 1'b0
`define PACK_HOLD 1'b1
`endif

package riscv_word_packer_pkg;

  localparam int XLEN = `XLEN;

  typedef enum logic {
    ST_FILL = `PACK_FILL,
    ST_HOLD = `PACK_HOLD
  } pack_state_e;

  // Index width that stays legal (>= 1 bit) even for a single slot.
  function automatic int idx_width(input int n_slot);
    return (n_slot > 1) ? $clog2(n_slot) : 1;
  endfunction

endpackage

// File: rtl/riscv_decoder.sv
// Enabled binary-to-one-hot decoder used as the per-slot write enable.
module riscv_decoder #(
  parameter int N_OUT = 2,
  parameter int IDX_W = 1
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N_OUT-1:0] onehot
);

  // One output bit high for the selected index while enabled.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/riscv_word_packer.sv
// Collects XLEN-bit words into an N_SLOT-wide concatenated bus and hands it
// off over a valid/ready handshake. Slot i lives at [XLEN*(i+1)-1 -: XLEN].
module riscv_word_packer
  import riscv_word_packer_pkg::*;
#(
  parameter int N_SLOT = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_word_valid,
  output logic                         o_word_ready,
  input  logic [`XLEN-1:0]             i_word_data,
  input  logic                         i_word_last,
  output logic                         o_pack_valid,
  input  logic                         i_pack_ready,
  output logic [N_SLOT*`XLEN-1:0]      o_pack_data,
  output logic [$clog2(N_SLOT+1)-1:0]  o_pack_cnt
);

  localparam int IDX_W = idx_width(N_SLOT);
  localparam int CNT_W = $clog2(N_SLOT + 1);

  pack_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [N_SLOT*`XLEN-1:0]   data_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [N_SLOT-1:0]         slot_we;
  logic                      word_acc;
  logic                      pack_acc;
  logic                      close_pack;

  assign word_acc   = i_word_valid & o_word_ready;
  assign pack_acc   = o_pack_valid & i_pack_ready;
  assign close_pack = i_word_last | (idx_q == IDX_W'(N_SLOT - 1));

  riscv_decoder #(
    .N_OUT (N_SLOT),
    .IDX_W (IDX_W)
  ) u_slot_dec (
    .en     (word_acc),
    .idx    (idx_q),
    .onehot (slot_we)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // Next state: close a pack on its last word, reopen on hand-off; flush wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (word_acc && close_pack) state_d = ST_HOLD;
      ST_HOLD: if (i_pack_ready)           state_d = ST_FILL;
      default:                             state_d = ST_FILL;
    endcase
    if (i_flush) state_d = ST_FILL;
  end

  // Handshake outputs depend only on state and flush, never on i_pack_ready.
  always_comb begin
    o_word_ready = (state_q == ST_FILL) & ~i_flush;
    o_pack_valid = (state_q == ST_HOLD);
  end

  // Slot registers, slot index and written-slot count.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      idx_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (pack_acc) begin
      idx_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (word_acc) begin
      for (int i = 0; i < N_SLOT; i++) begin
        if (slot_we[i]) data_q[`XLEN*(i+1)-1 -: `XLEN] <= i_word_data;
      end
      cnt_q <= CNT_W'(idx_q) + CNT_W'(1);
      idx_q <= close_pack ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign o_pack_data = data_q;
  assign o_pack_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_word_packer.sv
// Bench for riscv_word_packer with N_SLOT=4, XLEN=32: directed scenarios plus
// random traffic, all compared against a queue-based transaction model.
module tb_riscv_word_packer;

  localparam int N_SLOT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         word_last;
  logic         pack_valid;
  logic         pack_ready;
  logic [127:0] pack_data;
  logic [2:0]   pack_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words of the pack being built/held, and whether it is held.
  logic [31:0] m_words[$];
  bit          m_hold;

  riscv_word_packer #(.N_SLOT(N_SLOT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_word_valid (word_valid),
    .o_word_ready (word_ready),
    .i_word_data  (word_data),
    .i_word_last  (word_last),
    .o_pack_valid (pack_valid),
    .i_pack_ready (pack_ready),
    .o_pack_data  (pack_data),
    .o_pack_cnt   (pack_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] model_data();
    logic [127:0] p = '0;
    foreach (m_words[i]) p[32*i +: 32] = m_words[i];
    return p;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, advance.
  task automatic step(input bit v, input logic [31:0] d, input bit l,
                      input bit pr, input bit fl, input bit rs);
    @(negedge clk);
    word_valid = v; word_data = d; word_last = l;
    pack_ready = pr; flush = fl; rst = rs;
    #1;
    check("word_ready", 128'(word_ready), 128'(!m_hold && !fl));
    check("pack_valid", 128'(pack_valid), 128'(m_hold));
    check("pack_data",  pack_data, model_data());
    check("pack_cnt",   128'(pack_cnt), 128'(m_words.size()));
    if (rs || fl) begin
      m_words.delete(); m_hold = 0;
    end else if (m_hold) begin
      if (pr) begin m_words.delete(); m_hold = 0; end
    end else if (v) begin
      m_words.push_back(d);
      if (m_words.size() == N_SLOT || l) m_hold = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pr);
    step(0, 32'h0, 0, pr, 0, 0);
  endtask

  logic [127:0] held;

  initial begin
    rst = 1; flush = 0; word_valid = 0; word_data = 0; word_last = 0; pack_ready = 0;
    m_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_ready", 128'(word_ready), 128'(1));
    check("rst_valid", 128'(pack_valid), 128'(0));
    check("rst_data",  pack_data, 128'(0));
    check("rst_cnt",   128'(pack_cnt), 128'(0));

    // Full pack, back to back.
    step(1, 32'h11111111, 0, 1, 0, 0);
    step(1, 32'h22222222, 0, 1, 0, 0);
    step(1, 32'h33333333, 0, 1, 0, 0);
    step(1, 32'h44444444, 0, 1, 0, 0);
    check("full_valid", 128'(pack_valid), 128'(1));
    check("full_data", pack_data, 128'h44444444_33333333_22222222_11111111);
    check("full_cnt", 128'(pack_cnt), 128'(4));
    idle(1);
    check("full_ready_back", 128'(word_ready), 128'(1));
    check("full_valid_1cyc", 128'(pack_valid), 128'(0));

    // Early last.
    step(1, 32'hA, 0, 0, 0, 0);
    step(1, 32'hB, 1, 0, 0, 0);
    check("early_data", pack_data, {64'h0, 32'h0000000B, 32'h0000000A});
    check("early_cnt", 128'(pack_cnt), 128'(2));
    idle(1);

    // Consumer backpressure with a producer that keeps pushing.
    step(1, 32'h11111111, 0, 0, 0, 0);
    step(1, 32'h22222222, 0, 0, 0, 0);
    step(1, 32'h33333333, 0, 0, 0, 0);
    step(1, 32'h44444444, 0, 0, 0, 0);
    held = pack_data;
    for (int i = 0; i < 5; i++) step(1, $urandom, $urandom_range(0, 1), 0, 0, 0);
    check("bp_stable", pack_data, held);
    check("bp_cnt", 128'(pack_cnt), 128'(4));
    step(1, 32'hDEADBEEF, 0, 1, 0, 0);
    check("bp_handoff_data", pack_data, 128'(0));
    step(1, 32'h55555555, 0, 0, 0, 0);
    check("bp_next_cnt", 128'(pack_cnt), 128'(1));
    check("bp_next_data", pack_data, 128'h55555555);
    step(1, 32'h66666666, 1, 0, 0, 0);
    idle(1);

    // Producer gaps.
    for (int i = 1; i <= 4; i++) begin
      step(1, {8{i[3:0]}}, 0, 1, 0, 0);
      if (i < 4) begin idle(1); idle(1); end
    end
    check("gap_data", pack_data, 128'h44444444_33333333_22222222_11111111);
    idle(1);

    // Flush in FILL after two words, with a word offered in the same cycle.
    step(1, 32'hC0C0C0C0, 0, 0, 0, 0);
    step(1, 32'hC1C1C1C1, 0, 0, 0, 0);
    step(1, 32'hC2C2C2C2, 0, 0, 1, 0);
    check("flush_cnt", 128'(pack_cnt), 128'(0));
    check("flush_data", pack_data, 128'(0));
    step(1, 32'h01010101, 0, 0, 0, 0);
    step(1, 32'h02020202, 0, 0, 0, 0);
    step(1, 32'h03030303, 0, 0, 0, 0);
    step(1, 32'h04040404, 0, 0, 0, 0);
    check("flush_new", pack_data, 128'h04040404_03030303_02020202_01010101);

    // Flush in HOLD together with pack ready: pack discarded.
    step(0, 32'h0, 0, 1, 1, 0);
    check("flushhold_valid", 128'(pack_valid), 128'(0));
    check("flushhold_data", pack_data, 128'(0));
    idle(1);

    // Reset after three words.
    step(1, 32'h77777777, 0, 0, 0, 0);
    step(1, 32'h88888888, 0, 0, 0, 0);
    step(1, 32'h99999999, 0, 0, 0, 0);
    step(1, 32'hAAAAAAAA, 0, 0, 0, 1);
    check("rstmid_cnt", 128'(pack_cnt), 128'(0));
    check("rstmid_data", pack_data, 128'(0));
    check("rstmid_valid", 128'(pack_valid), 128'(0));
    check("rstmid_ready", 128'(word_ready), 128'(1));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0,
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 97) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
